// File: rtl/split_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : split_mem_responder
// Brief   : Fixed-latency responder for split I/D memory ports, served from a
//           single-ported word array. Optional MEM_ALIGN_CHECK_EN adds align_err.
// Revision: 1.0 - initial release
// ============================================================================
module split_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_read,
    input  logic [15:0] i_address,
    output logic [15:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_byte_enable,
    output logic [15:0] d_rdata,
    output logic        d_resp
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        align_err
`endif
);

    localparam int         DEPTH        = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_load_count = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_count;
    logic [3:0]            w_next_count;
    logic [DEPTH_LOG2-1:0] r_index;
    logic [15:0]           r_wdata;
    logic [1:0]            r_mask;
    logic                  r_write;
    logic                  w_accept_d;
    logic                  w_accept_i;
    logic                  w_commit;
    logic [15:0]           w_word;
    logic [15:0]           r_mem [DEPTH];

    // Bit 0 and the bits above the index only alias; they carry no state.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{i_address, d_address};

    assign w_word = r_mem[r_index];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
            r_index <= '0;
            r_wdata <= 16'd0;
            r_mask  <= 2'b00;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_accept_d) begin
                r_index <= d_address[DEPTH_LOG2:1];
                r_wdata <= d_wdata;
                r_mask  <= d_byte_enable;
                r_write <= d_write;
            end else if (w_accept_i) begin
                r_index <= i_address[DEPTH_LOG2:1];
                r_write <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_accept_d   = 1'b0;
        w_accept_i   = 1'b0;
        w_commit     = 1'b0;
        i_resp       = 1'b0;
        i_rdata      = 16'd0;
        d_resp       = 1'b0;
        d_rdata      = 16'd0;
        case (r_state)
            ST_IDLE: begin
                // Data side wins: it belongs to the older instruction in the pipe.
                if (d_read || d_write) begin
                    w_accept_d   = 1'b1;
                    w_next_state = ST_BUSY_D;
                    w_next_count = c_load_count;
                end else if (i_read) begin
                    w_accept_i   = 1'b1;
                    w_next_state = ST_BUSY_I;
                    w_next_count = c_load_count;
                end
            end
            ST_BUSY_I: begin
                if (r_count == 4'd0) begin
                    i_resp       = 1'b1;
                    i_rdata      = w_word;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_count = r_count - 4'd1;
                end
            end
            ST_BUSY_D: begin
                if (r_count == 4'd0) begin
                    d_resp       = 1'b1;
                    d_rdata      = w_word;
                    w_commit     = r_write;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_count = r_count - 4'd1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_count = 4'd0;
            end
        endcase
    end

    // Store lands on the edge closing the d_resp cycle, so d_rdata shows the old word.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            if (r_mask[0]) begin
                r_mem[r_index][7:0] <= r_wdata[7:0];
            end
            if (r_mask[1]) begin
                r_mem[r_index][15:8] <= r_wdata[15:8];
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_misalign <= 1'b0;
        end else if (w_accept_d) begin
            r_misalign <= (d_byte_enable == 2'b11) && d_address[0];
        end else if (w_accept_i) begin
            r_misalign <= i_address[0];
        end
    end

    assign align_err = (i_resp || d_resp) && r_misalign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_split_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_split_mem_responder
// Brief   : Self-checking bench for split_mem_responder against a word-array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_split_mem_responder;

    localparam int DL    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << DL;
    localparam int TMO   = LAT + 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_read;
    logic [15:0] i_address;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [1:0]  d_byte_enable;
    logic [15:0] d_rdata;
    logic        d_resp;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] model [DEPTH];

    always #5 clk = ~clk;

    split_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_rdata       (i_rdata),
        .i_resp        (i_resp),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_wdata       (d_wdata),
        .d_byte_enable (d_byte_enable),
        .d_rdata       (d_rdata),
        .d_resp        (d_resp)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .align_err     (align_err)
`endif
    );

    function automatic int widx(input logic [15:0] a);
        return int'(a[DL:1]);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    // Single access driven from a negedge; request fields scrambled while busy.
    task automatic access(input bit is_d, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, input bit rd, input bit wr,
                          output logic [15:0] rdata, output int lat, output bit wrong,
                          output bit stuck, output bit align);
        rdata = 16'd0; lat = -1; wrong = 1'b0; stuck = 1'b0; align = 1'b0;
        if (is_d) begin
            d_read = rd; d_write = wr; d_address = addr; d_wdata = wdata; d_byte_enable = be;
        end else begin
            i_read = 1'b1; i_address = addr;
        end
        for (int k = 1; k <= TMO; k++) begin
            @(posedge clk); #1;
            if (is_d ? i_resp : d_resp) wrong = 1'b1;
            if (is_d ? d_resp : i_resp) begin
                lat   = k;
                rdata = is_d ? d_rdata : i_rdata;
`ifdef MEM_ALIGN_CHECK_EN
                align = align_err;
`endif
                break;
            end
            @(negedge clk);
            i_address     = 16'($urandom);
            d_address     = 16'($urandom);
            d_wdata       = 16'($urandom);
            d_byte_enable = 2'($urandom);
        end
        @(negedge clk);
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        @(posedge clk); #1;
        if (i_resp || d_resp) stuck = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_read = 1'b1; d_read = 1'b0; d_write = 1'b1;
        i_address = 16'h0010; d_address = 16'h0020; d_wdata = 16'hFFFF; d_byte_enable = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({i_resp, d_resp} !== 2'b00) begin
            failures++; $display("FAIL reset_resp: got %b expected 00", {i_resp, d_resp});
        end
        checks++;
        if ({i_rdata, d_rdata} !== 32'd0) begin
            failures++; $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata});
        end
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (align_err !== 1'b0) begin
            failures++; $display("FAIL reset_align: got %b expected 0", align_err);
        end
`endif
        @(negedge clk);
        i_read = 1'b0; d_write = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({i_resp, d_resp, i_rdata, d_rdata} !== 34'd0) begin
            failures++; $display("FAIL idle_after_reset: got %h expected 0",
                                 {i_resp, d_resp, i_rdata, d_rdata});
        end
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [15:0] rd; int lat; bit wrong, stuck, al;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 16'($urandom);
            access(1'b1, 16'(i * 2), model[i], 2'b11, 1'b0, 1'b1, rd, lat, wrong, stuck, al);
            checks++;
            if (lat != LAT || wrong || stuck) begin
                failures++; $display("FAIL fill_latency[%0d]: got %0d/%b/%b expected %0d/0/0",
                                     i, lat, wrong, stuck, LAT);
            end
        end
    endtask

    task automatic test_fetch();
        logic [15:0] rd, a; int lat; bit wrong, stuck, al;
        access(1'b1, 16'h0010, 16'h1234, 2'b11, 1'b0, 1'b1, rd, lat, wrong, stuck, al);
        model[widx(16'h0010)] = 16'h1234;
        access(1'b0, 16'h0010, 16'h0, 2'b00, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
        checks++;
        if (rd !== 16'h1234 || lat != LAT || wrong || stuck) begin
            failures++; $display("FAIL fetch_0010: got %h lat %0d wrong %b stuck %b expected 1234 lat %0d",
                                 rd, lat, wrong, stuck, LAT);
        end
        for (int n = 0; n < 24; n++) begin
            a = 16'($urandom);
            access(1'b0, a, 16'h0, 2'b00, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
            checks++;
            if (rd !== model[widx(a)] || lat != LAT || wrong || stuck) begin
                failures++; $display("FAIL fetch_rand @%h: got %h lat %0d wrong %b stuck %b expected %h lat %0d",
                                     a, rd, lat, wrong, stuck, model[widx(a)], LAT);
            end
        end
    endtask

    task automatic test_store();
        logic [15:0] rd, a, wd, exp; logic [1:0] be; bit r, w; int lat; bit wrong, stuck, al;
        access(1'b1, 16'h0020, 16'h5555, 2'b11, 1'b0, 1'b1, rd, lat, wrong, stuck, al);
        model[widx(16'h0020)] = 16'h5555;
        access(1'b1, 16'h0020, 16'hABCD, 2'b01, 1'b0, 1'b1, rd, lat, wrong, stuck, al);
        checks++;
        if (rd !== 16'h5555 || lat != LAT || wrong || stuck) begin
            failures++; $display("FAIL store_prewrite: got %h lat %0d expected 5555 lat %0d", rd, lat, LAT);
        end
        model[widx(16'h0020)] = 16'h55CD;
        access(1'b1, 16'h0020, 16'h0, 2'b00, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
        checks++;
        if (rd !== 16'h55CD || lat != LAT) begin
            failures++; $display("FAIL store_readback: got %h lat %0d expected 55CD lat %0d", rd, lat, LAT);
        end
        for (int n = 0; n < 30; n++) begin
            a  = 16'($urandom);
            wd = 16'($urandom);
            be = 2'($urandom);
            w  = 1'b1;
            r  = 1'($urandom);
            exp = model[widx(a)];
            access(1'b1, a, wd, be, r, w, rd, lat, wrong, stuck, al);
            checks++;
            if (rd !== exp || lat != LAT || wrong || stuck) begin
                failures++; $display("FAIL store_rand @%h be %b rd %b: got %h lat %0d expected %h lat %0d",
                                     a, be, r, rd, lat, exp, LAT);
            end
            model[widx(a)] = merge(exp, wd, be);
            access(1'b1, a, 16'h0, 2'b00, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
            checks++;
            if (rd !== model[widx(a)]) begin
                failures++; $display("FAIL store_rand_readback @%h be %b: got %h expected %h",
                                     a, be, rd, model[widx(a)]);
            end
        end
    endtask

    task automatic test_arbitration();
        logic [15:0] ia, da, idata, ddata; int icyc, dcyc; bit both;
        for (int n = 0; n < 3; n++) begin
            ia = 16'($urandom); da = 16'($urandom);
            icyc = -1; dcyc = -1; both = 1'b0; idata = 16'h0; ddata = 16'h0;
            i_address = ia; d_address = da; i_read = 1'b1; d_read = 1'b1;
            for (int k = 1; k <= 3 * TMO; k++) begin
                @(posedge clk); #1;
                if (i_resp && d_resp) both = 1'b1;
                if (d_resp && dcyc < 0) begin dcyc = k; ddata = d_rdata; end
                if (i_resp && icyc < 0) begin icyc = k; idata = i_rdata; end
                @(negedge clk);
                if (d_resp) d_read = 1'b0;
                if (i_resp) i_read = 1'b0;
                if (icyc >= 0 && dcyc >= 0) break;
            end
            i_read = 1'b0; d_read = 1'b0;
            @(negedge clk);
            checks++;
            if (dcyc != LAT || icyc != 2 * LAT + 1 || both) begin
                failures++; $display("FAIL arb_timing: got d@%0d i@%0d both %b expected d@%0d i@%0d",
                                     dcyc, icyc, both, LAT, 2 * LAT + 1);
            end
            checks++;
            if (ddata !== model[widx(da)] || idata !== model[widx(ia)]) begin
                failures++; $display("FAIL arb_data: got d %h i %h expected d %h i %h",
                                     ddata, idata, model[widx(da)], model[widx(ia)]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] rd; int lat; bit wrong, stuck, al, seen;
        access(1'b1, 16'h0040, 16'h0000, 2'b11, 1'b0, 1'b1, rd, lat, wrong, stuck, al);
        model[widx(16'h0040)] = 16'h0000;
        d_write = 1'b1; d_address = 16'h0040; d_wdata = 16'hFFFF; d_byte_enable = 2'b11;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({i_resp, d_resp, i_rdata, d_rdata} !== 34'd0) begin
            failures++; $display("FAIL midop_reset_outputs: got %h expected 0",
                                 {i_resp, d_resp, i_rdata, d_rdata});
        end
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (d_resp || i_resp) seen = 1'b1;
        end
        @(negedge clk);
        d_write = 1'b0;
        reset_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (d_resp || i_resp) seen = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (seen) begin
            failures++; $display("FAIL midop_no_resp: got resp 1 expected 0");
        end
        access(1'b1, 16'h0040, 16'h0, 2'b00, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
        checks++;
        if (rd !== 16'h0000 || lat != LAT) begin
            failures++; $display("FAIL midop_no_commit: got %h lat %0d expected 0000 lat %0d", rd, lat, LAT);
        end
    endtask

    task automatic test_alias();
        logic [15:0] rd, a, b, wd; int lat; bit wrong, stuck, al;
        access(1'b1, 16'h0002, 16'h7777, 2'b11, 1'b0, 1'b1, rd, lat, wrong, stuck, al);
        model[widx(16'h0002)] = 16'h7777;
        access(1'b0, 16'h0802, 16'h0, 2'b00, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
        checks++;
        if (rd !== 16'h7777) begin
            failures++; $display("FAIL alias_0802: got %h expected 7777", rd);
        end
        for (int n = 0; n < 8; n++) begin
            a  = 16'($urandom);
            b  = a ^ (16'($urandom_range(31, 1)) << (DL + 1)) ^ 16'($urandom_range(1, 0));
            wd = 16'($urandom);
            access(1'b1, a, wd, 2'b11, 1'b0, 1'b1, rd, lat, wrong, stuck, al);
            model[widx(a)] = wd;
            access(1'b0, b, 16'h0, 2'b00, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
            checks++;
            if (rd !== wd) begin
                failures++; $display("FAIL alias_rand %h->%h: got %h expected %h", a, b, rd, wd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, got; int k; bit side_d;
        for (int n = 0; n < 8; n++) begin
            side_d = (n % 2) == 0;
            a = 16'($urandom);
            i_read = !side_d; d_read = side_d; d_write = 1'b0;
            i_address = a; d_address = a;
            k = 0; got = 16'h0;
            do begin
                @(posedge clk); #1;
                k++;
            end while (!(side_d ? d_resp : i_resp) && k < TMO + 2);
            got = side_d ? d_rdata : i_rdata;
            checks++;
            if (k != ((n == 0) ? LAT : LAT + 1) || got !== model[widx(a)]) begin
                failures++; $display("FAIL b2b[%0d]: got %0d cycles data %h expected %0d cycles data %h",
                                     n, k, got, (n == 0) ? LAT : LAT + 1, model[widx(a)]);
            end
            @(negedge clk);
        end
        i_read = 1'b0; d_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_align();
        logic [15:0] rd; int lat; bit wrong, stuck, al;
        access(1'b1, 16'h0031, 16'h0, 2'b11, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
        checks++;
        if (al !== 1'b1 || rd !== model[widx(16'h0030)] || lat != LAT) begin
            failures++; $display("FAIL align_d_be11: got err %b data %h expected err 1 data %h",
                                 al, rd, model[widx(16'h0030)]);
        end
        access(1'b1, 16'h0031, 16'h0, 2'b10, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
        checks++;
        if (al !== 1'b0) begin
            failures++; $display("FAIL align_d_be10: got %b expected 0", al);
        end
        access(1'b0, 16'h0011, 16'h0, 2'b00, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
        checks++;
        if (al !== 1'b1 || rd !== model[widx(16'h0010)]) begin
            failures++; $display("FAIL align_i_odd: got err %b data %h expected err 1 data %h",
                                 al, rd, model[widx(16'h0010)]);
        end
        access(1'b0, 16'h0010, 16'h0, 2'b00, 1'b1, 1'b0, rd, lat, wrong, stuck, al);
        checks++;
        if (al !== 1'b0) begin
            failures++; $display("FAIL align_i_even: got %b expected 0", al);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = 16'h0; d_address = 16'h0; d_wdata = 16'h0; d_byte_enable = 2'b00;
        reset_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_fetch();
        test_store();
        test_arbitration();
        test_reset_midop();
        test_alias();
        test_back_to_back();
`ifdef MEM_ALIGN_CHECK_EN
        test_align();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
